// File: rtl/lsu_byte_sequencer.sv
// Load/store sequencer in front of the 8-bit dual-port data RAM.
// Splits byte/half/word accesses into two-byte beats on ports A/B.
module lsu_byte_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [7:0]        ram_din_a,
  output logic              ram_we_a,
  input  logic [7:0]        ram_dout_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [7:0]        ram_din_b,
  output logic              ram_we_b,
  input  logic [7:0]        ram_dout_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;

  logic is_byte;
  logic is_word;
  logic accept;

  assign is_byte = (size_q == 2'b00);
  assign is_word = size_q[1];
  assign accept  = req_valid & req_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Request latch on accept; load bytes captured each beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == BEAT0) begin
        buf_q[7:0]  <= ram_dout_a;
        buf_q[15:8] <= ram_dout_b;
      end
      if (state == BEAT1) begin
        buf_q[23:16] <= ram_dout_a;
        buf_q[31:24] <= ram_dout_b;
      end
    end
  end

  // Next state and RAM port drive; ports are quiet outside the beats.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    ram_addr_a = '0;
    ram_addr_b = '0;
    ram_din_a  = '0;
    ram_din_b  = '0;
    ram_we_a   = 1'b0;
    ram_we_b   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = BEAT0;
      end
      BEAT0: begin
        ram_addr_a = addr_q;
        ram_addr_b = addr_q + ADDR_W'(1);
        ram_din_a  = wdata_q[7:0];
        ram_din_b  = wdata_q[15:8];
        ram_we_a   = we_q;
        ram_we_b   = we_q & ~is_byte;
        state_nx   = is_word ? BEAT1 : RESP;
      end
      BEAT1: begin
        ram_addr_a = addr_q + ADDR_W'(2);
        ram_addr_b = addr_q + ADDR_W'(3);
        ram_din_a  = wdata_q[23:16];
        ram_din_b  = wdata_q[31:24];
        ram_we_a   = we_q;
        ram_we_b   = we_q;
        state_nx   = RESP;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Response: single-cycle pulse with extended load data.
  always_comb begin
    rsp_valid = (state == RESP);
    rsp_rdata = '0;
    if (rsp_valid && !we_q) begin
      unique case (1'b1)
        (size_q == 2'b00):
          rsp_rdata = {{24{~uns_q & buf_q[7]}}, buf_q[7:0]};
        (size_q == 2'b01):
          rsp_rdata = {{16{~uns_q & buf_q[15]}}, buf_q[15:0]};
        default:
          rsp_rdata = buf_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Bench for lsu_byte_sequencer: vector table, RAM model,
// back-to-back requests and reset in the middle of a word store.
module tb_lsu_byte_sequencer;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] ram_addr_a;
  logic [7:0]    ram_din_a;
  logic          ram_we_a;
  logic [7:0]    ram_dout_a;
  logic [AW-1:0] ram_addr_b;
  logic [7:0]    ram_din_b;
  logic          ram_we_b;
  logic [7:0]    ram_dout_b;

  logic [7:0] mem [0:(1<<AW)-1];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_byte_sequencer #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .ram_addr_a   (ram_addr_a),
    .ram_din_a    (ram_din_a),
    .ram_we_a     (ram_we_a),
    .ram_dout_a   (ram_dout_a),
    .ram_addr_b   (ram_addr_b),
    .ram_din_b    (ram_din_b),
    .ram_we_b     (ram_we_b),
    .ram_dout_b   (ram_dout_b)
  );

  assign ram_dout_a = mem[ram_addr_a];
  assign ram_dout_b = mem[ram_addr_b];

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
  end

  function automatic logic [7:0] init_byte(int a);
    logic [7:0] v;
    v = a[7:0] ^ 8'hA5;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    int            exp_lat;
    logic          exp_wea;
    logic          exp_web;
  } vec_t;

  vec_t vt [13];

  task automatic run_vec(int i);
    int         lat;
    logic [31:0] rd;
    logic       wa;
    logic       wb;
    lat = 0;
    rd  = 32'hx;
    wa  = 1'b0;
    wb  = 1'b0;
    @(negedge clk);
    req_we       = vt[i].we;
    req_size     = vt[i].size;
    req_unsigned = vt[i].uns;
    req_addr     = vt[i].addr;
    req_wdata    = vt[i].wdata;
    req_valid    = 1'b1;
    chk($sformatf("v%0d_ready", i), {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      wa |= ram_we_a;
      wb |= ram_we_b;
      if (rsp_valid) begin
        lat = k;
        rd  = rsp_rdata;
        break;
      end
    end
    chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
    chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
    chk($sformatf("v%0d_we_ab", i), {30'd0, wa, wb},
        {30'd0, vt[i].exp_wea, vt[i].exp_web});
  endtask

  initial begin
    int acc;
    int rsp;
    int pat_bad;
    int seen_rsp;

    for (int a = 0; a < (1 << AW); a++) mem[a] = init_byte(a);

    vt[0]  = '{1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 3, 1'b1, 1'b1};
    vt[1]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 3, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 2'b00, 1'b0, 10'h020, 32'h12345680, 32'h0, 2, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 2'b00, 1'b0, 10'h020, 32'h0, 32'hFFFFFF80, 2, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 2'b00, 1'b1, 10'h020, 32'h0, 32'h00000080, 2, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 2'b01, 1'b0, 10'h031, 32'hABCD8001, 32'h0, 2, 1'b1, 1'b1};
    vt[6]  = '{1'b0, 2'b01, 1'b0, 10'h031, 32'h0, 32'hFFFF8001, 2, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 2'b01, 1'b1, 10'h031, 32'h0, 32'h00008001, 2, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 2'b10, 1'b0, 10'h3FF, 32'h11223344, 32'h0, 3, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 2'b10, 1'b0, 10'h3FF, 32'h0, 32'h11223344, 3, 1'b0, 1'b0};
    vt[10] = '{1'b0, 2'b11, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 3, 1'b0, 1'b0};
    vt[11] = '{1'b0, 2'b00, 1'b0, 10'h011, 32'h0, 32'hFFFFFFBE, 2, 1'b0, 1'b0};
    vt[12] = '{1'b0, 2'b01, 1'b1, 10'h012, 32'h0, 32'h0000DEAD, 2, 1'b0, 1'b0};

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_we", {30'd0, ram_we_a, ram_we_b}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i);

    chk("mem_010", {24'd0, mem[10'h010]}, 32'hEF);
    chk("mem_011", {24'd0, mem[10'h011]}, 32'hBE);
    chk("mem_012", {24'd0, mem[10'h012]}, 32'hAD);
    chk("mem_013", {24'd0, mem[10'h013]}, 32'hDE);
    chk("mem_020", {24'd0, mem[10'h020]}, 32'h80);
    chk("mem_021_kept", {24'd0, mem[10'h021]}, 32'h84);
    chk("mem_031", {24'd0, mem[10'h031]}, 32'h01);
    chk("mem_032", {24'd0, mem[10'h032]}, 32'h80);
    chk("mem_033_kept", {24'd0, mem[10'h033]}, 32'h96);
    chk("mem_3ff", {24'd0, mem[10'h3FF]}, 32'h44);
    chk("mem_000", {24'd0, mem[10'h000]}, 32'h33);
    chk("mem_001", {24'd0, mem[10'h001]}, 32'h22);
    chk("mem_002", {24'd0, mem[10'h002]}, 32'h11);
    chk("mem_003_kept", {24'd0, mem[10'h003]}, 32'hA6);

    // back-to-back byte loads with req_valid held high
    @(negedge clk);
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b1;
    req_addr     = 10'h020;
    req_valid    = 1'b1;
    acc     = 0;
    rsp     = 0;
    pat_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) acc++;
      if (rsp_valid) begin
        rsp++;
        if (rsp_rdata !== 32'h80) pat_bad++;
      end
      if (req_ready !== (i % 3 == 0)) pat_bad++;
      if (rsp_valid !== (i % 3 == 2)) pat_bad++;
      @(posedge clk);
    end
    #1 req_valid = 1'b0;
    chk("b2b_accepts", acc, 4);
    chk("b2b_responses", rsp, 4);
    chk("b2b_pattern_errs", pat_bad, 0);

    // reset asserted during BEAT1 of a word store
    @(negedge clk);
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 10'h040;
    req_wdata = 32'hAABBCCDD;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_beat1_addr", {22'd0, ram_addr_a}, 32'h042);
    chk("rstmid_beat1_we", {30'd0, ram_we_a, ram_we_b}, 32'd3);
    rst = 1'b1;
    #1;
    chk("rstmid_we_off", {30'd0, ram_we_a, ram_we_b}, 32'd0);
    seen_rsp = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
    end
    chk("rstmid_no_rsp", seen_rsp, 0);
    chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid_mem_040", {24'd0, mem[10'h040]}, 32'hDD);
    chk("rstmid_mem_041", {24'd0, mem[10'h041]}, 32'hCC);
    chk("rstmid_mem_042", {24'd0, mem[10'h042]}, 32'hE7);
    chk("rstmid_mem_043", {24'd0, mem[10'h043]}, 32'hE6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
